// File: rtl/apb_timer_pkg.sv
// -----------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the APB timer: register byte offsets, CTRL bit
// positions, the CTRL register layout and a helper that packs CTRL for reads.
// -----------------------------------------------------------------------------
package apb_timer_pkg;

    // Register byte offsets within the 16-byte window
    localparam logic [3:0] CTRL_OFF    = 4'h0;
    localparam logic [3:0] LOAD_OFF    = 4'h4;
    localparam logic [3:0] VALUE_OFF   = 4'h8;
    localparam logic [3:0] INTSTAT_OFF = 4'hC;

    // CTRL bit positions
    localparam int EN_BIT       = 0;
    localparam int IRQEN_BIT    = 1;
    localparam int RELOAD_BIT   = 2;
    localparam int PRESCALE_LSB = 8;
    localparam int PRESCALE_MSB = 15;

    typedef struct packed {
        logic [7:0] prescale;
        logic       reload;
        logic       irqen;
        logic       en;
    } ctrl_t;

    // CTRL as seen on the bus; unused bits read as 0
    function automatic logic [31:0] ctrl_rdata(input ctrl_t c);
        logic [31:0] r;
        r                             = '0;
        r[EN_BIT]                     = c.en;
        r[IRQEN_BIT]                  = c.irqen;
        r[RELOAD_BIT]                 = c.reload;
        r[PRESCALE_MSB:PRESCALE_LSB]  = c.prescale;
        return r;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// -----------------------------------------------------------------------------
// apb_timer_if
// APB3 completer-side bus bundle for the timer.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : driven by the requester (bridge)
//   PRDATA/PREADY/PSLVERR            : driven by the timer
// Modports: master (bridge / bench side), slave (timer side).
// -----------------------------------------------------------------------------
interface apb_timer_if #(
    parameter int ADDRWIDTH = 16
) ();
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_prescaler.sv
// -----------------------------------------------------------------------------
// apb_timer_prescaler
// Divides HCLK by (prescale+1) while enabled, producing a one-cycle tick.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   en       in  count enable; counter held at 0 while low
//   prescale in  terminal count (tick every prescale+1 cycles)
//   restart  in  force the counter back to 0 on this edge
//   tick     out high in the cycle where the count equals prescale
// -----------------------------------------------------------------------------
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] prescale,
    input  logic       restart,
    output logic       tick
);

    logic [7:0] pre_cnt_q;
    logic [7:0] pre_cnt_d;

    assign tick = en & (pre_cnt_q == prescale);

    always_comb begin
        pre_cnt_d = pre_cnt_q + 8'd1;
        if (!en || restart || tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// -----------------------------------------------------------------------------
// apb_timer
// APB3 timer: 32-bit down-counter with 8-bit prescaler, periodic or one-shot,
// level interrupt on underflow. Zero wait states.
//   HCLK     in  clock for all logic
//   HRESETn  in  asynchronous active-low reset
//   apb      APB3 completer port (PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//            PRDATA, PREADY, PSLVERR)
//   TIMERINT out registered interrupt = raw_int & IRQEN
// Registers: 0x0 CTRL, 0x4 LOAD, 0x8 VALUE (RO), 0xC INTSTAT (W1C bit0).
// -----------------------------------------------------------------------------
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    apb_timer_if.slave apb,
    output logic       TIMERINT
);

    logic [3:0]           reg_off;
    logic                 mapped;
    logic                 unused_paddr;
    logic                 wr_commit;
    logic                 ctrl_wr;
    logic                 load_wr;
    logic                 intstat_wr;
    logic                 tick;
    logic                 underflow;
    logic                 restart;
    ctrl_t                ctrl_wdata;
    ctrl_t                ctrl_q, ctrl_d;
    logic [DATAWIDTH-1:0] load_q, load_d;
    logic [DATAWIDTH-1:0] value_q, value_d;
    logic                 raw_int_q, raw_int_d;
    logic                 timerint_q, timerint_d;
    logic [31:0]          prdata;

    // Byte lanes are ignored; only the word index selects a register
    assign reg_off      = {apb.PADDR[3:2], 2'b00};
    assign mapped       = (apb.PADDR[ADDRWIDTH-1:4] == '0);
    assign unused_paddr = ^apb.PADDR[1:0];

    assign wr_commit  = apb.PSEL & apb.PENABLE & apb.PWRITE & mapped;
    assign ctrl_wr    = wr_commit & (reg_off == CTRL_OFF);
    assign load_wr    = wr_commit & (reg_off == LOAD_OFF);
    assign intstat_wr = wr_commit & (reg_off == INTSTAT_OFF);

    assign ctrl_wdata.en       = apb.PWDATA[EN_BIT];
    assign ctrl_wdata.irqen    = apb.PWDATA[IRQEN_BIT];
    assign ctrl_wdata.reload   = apb.PWDATA[RELOAD_BIT];
    assign ctrl_wdata.prescale = apb.PWDATA[PRESCALE_MSB:PRESCALE_LSB];

    // A LOAD write or a PRESCALE change starts a fresh prescale period
    assign restart = load_wr | (ctrl_wr & (ctrl_wdata.prescale != ctrl_q.prescale));

    // A LOAD write overrides any tick on the same edge, including underflow
    assign underflow = tick & (value_q == '0) & ~load_wr;

    apb_timer_prescaler u_prescaler (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .en       (ctrl_q.en),
        .prescale (ctrl_q.prescale),
        .restart  (restart),
        .tick     (tick)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        value_d   = value_q;
        raw_int_d = raw_int_q;

        if (tick && !load_wr) begin
            if (value_q != '0) begin
                value_d = value_q - DATAWIDTH'(1);
            end else if (ctrl_q.reload) begin
                value_d = load_q;
            end else begin
                ctrl_d.en = 1'b0;
            end
        end

        // Clear first so a simultaneous underflow keeps the flag set
        if (intstat_wr && apb.PWDATA[0]) begin
            raw_int_d = 1'b0;
        end
        if (underflow) begin
            raw_int_d = 1'b1;
        end

        // Bus write wins over the one-shot auto-disable
        if (ctrl_wr) begin
            ctrl_d = ctrl_wdata;
        end
        if (load_wr) begin
            load_d  = apb.PWDATA;
            value_d = apb.PWDATA;
        end

        // Registered interrupt tracks next-state flag so it moves on the same edge
        timerint_d = raw_int_d & ctrl_d.irqen;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            value_q    <= '0;
            raw_int_q  <= 1'b0;
            timerint_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            value_q    <= value_d;
            raw_int_q  <= raw_int_d;
            timerint_q <= timerint_d;
        end
    end

    always_comb begin
        prdata = '0;
        if (apb.PSEL && !apb.PWRITE && mapped) begin
            case (reg_off)
                CTRL_OFF:    prdata = ctrl_rdata(ctrl_q);
                LOAD_OFF:    prdata = load_q;
                VALUE_OFF:   prdata = value_q;
                INTSTAT_OFF: prdata = {31'b0, raw_int_q};
                default:     prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;
    assign TIMERINT    = timerint_q;

endmodule

// File: tb/tb_apb_timer.sv
module tb_apb_timer;
    import apb_timer_pkg::*;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    logic TIMERINT;

    apb_timer_if #(.ADDRWIDTH(16)) bus ();

    apb_timer #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .apb      (bus),
        .TIMERINT (TIMERINT)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    always @(posedge HCLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en, m_irq, m_rel, m_raw, m_tint;
    logic [7:0]  m_ps;
    logic [31:0] m_load, m_value;
    int          m_pre;

    always @(posedge HCLK or negedge HRESETn) begin : model
        logic        wr, ld, tk, n_en, n_irq, n_rel, n_raw;
        logic [1:0]  ro;
        logic [7:0]  n_ps;
        logic [31:0] n_load, n_value;
        int          n_pre;
        if (!HRESETn) begin
            m_en = 0; m_irq = 0; m_rel = 0; m_raw = 0; m_tint = 0;
            m_ps = 0; m_load = 0; m_value = 0; m_pre = 0;
        end else begin
            wr = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR[15:4] == 12'h0);
            ro = bus.PADDR[3:2];
            ld = wr && (ro == 2'd1);
            tk = m_en && (m_pre == int'(m_ps));
            n_en = m_en; n_irq = m_irq; n_rel = m_rel; n_raw = m_raw;
            n_ps = m_ps; n_load = m_load; n_value = m_value;
            n_pre = (m_en && !tk) ? m_pre + 1 : 0;
            if (tk && !ld) begin
                if (m_value != 0) n_value = m_value - 1;
                else begin
                    n_raw = 1;
                    if (m_rel) n_value = m_load;
                    else n_en = 0;
                end
            end
            if (wr && ro == 2'd3 && bus.PWDATA[0] && !(tk && !ld && m_value == 0)) n_raw = 0;
            if (wr && ro == 2'd0) begin
                n_en  = bus.PWDATA[0];
                n_irq = bus.PWDATA[1];
                n_rel = bus.PWDATA[2];
                n_ps  = bus.PWDATA[15:8];
                if (n_ps != m_ps) n_pre = 0;
            end
            if (ld) begin
                n_load = bus.PWDATA; n_value = bus.PWDATA; n_pre = 0;
            end
            m_en = n_en; m_irq = n_irq; m_rel = n_rel; m_raw = n_raw;
            m_ps = n_ps; m_load = n_load; m_value = n_value; m_pre = n_pre;
            m_tint = n_raw && n_irq;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge HCLK) begin : compare
        logic [31:0] exp_rd;
        logic        mp;
        if (chk_on) begin
            mp     = (bus.PADDR[15:4] == 12'h0);
            exp_rd = 32'h0;
            if (bus.PSEL && !bus.PWRITE && mp) begin
                case (bus.PADDR[3:2])
                    2'd0: exp_rd = {16'h0, m_ps, 5'h0, m_rel, m_irq, m_en};
                    2'd1: exp_rd = m_load;
                    2'd2: exp_rd = m_value;
                    default: exp_rd = {31'h0, m_raw};
                endcase
            end
            check("cyc_prdata",   bus.PRDATA,  exp_rd);
            check("cyc_pslverr",  {31'h0, bus.PSLVERR}, {31'h0, bus.PSEL && bus.PENABLE && !mp});
            check("cyc_pready",   {31'h0, bus.PREADY},  32'h1);
            check("cyc_timerint", {31'h0, TIMERINT},    {31'h0, m_tint});
        end
    end

    // ---------------- interrupt rise recorder ----------------
    int   rise_q[$];
    logic tint_prev = 1'b0;

    always begin
        @(posedge HCLK);
        #1;
        if (TIMERINT === 1'b1 && tint_prev !== 1'b1) rise_q.push_back(cyc);
        tint_prev = TIMERINT;
    end

    task automatic check_rise(input string name, input int idx, input int base, input int exp_delta);
        if (idx < rise_q.size()) check(name, rise_q[idx] - base, exp_delta);
        else check(name, 32'hFFFF_FFFF, exp_delta);
    endtask

    // ---------------- APB tasks ----------------
    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                             output int commit, output logic err);
        @(posedge HCLK); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = addr; bus.PWDATA = data;
        @(posedge HCLK); #1;
        bus.PENABLE = 1;
        @(negedge HCLK);
        err = bus.PSLVERR;
        @(posedge HCLK); #1;
        commit = cyc;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data, output logic err);
        @(posedge HCLK); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = addr;
        @(posedge HCLK); #1;
        bus.PENABLE = 1;
        @(negedge HCLK);
        data = bus.PRDATA;
        err  = bus.PSLVERR;
        @(posedge HCLK); #1;
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    function automatic logic [15:0] a(input logic [3:0] off);
        return {12'h0, off};
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        int          e0, c;
        logic [31:0] d;
        logic        err;

        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        repeat (2) @(posedge HCLK);
        chk_on = 1'b1;
        #1;
        check("rst_timerint", {31'h0, TIMERINT}, 32'h0);
        check("rst_pready",   {31'h0, bus.PREADY}, 32'h1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Reset values
        apb_read(a(CTRL_OFF), d, err);    check("rst_ctrl", d, 32'h0);
        apb_read(a(LOAD_OFF), d, err);    check("rst_load", d, 32'h0);
        apb_read(a(VALUE_OFF), d, err);   check("rst_value", d, 32'h0);
        apb_read(a(INTSTAT_OFF), d, err); check("rst_intstat", d, 32'h0);

        // Periodic mode, LOAD=3, PRESCALE=0
        apb_write(a(LOAD_OFF), 32'd3, c, err);
        rise_q.delete();
        apb_write(a(CTRL_OFF), 32'h7, e0, err);
        repeat (2) @(posedge HCLK);
        apb_write(a(INTSTAT_OFF), 32'h1, c, err);
        check("clr_drop", {31'h0, TIMERINT}, 32'h0);
        repeat (1) @(posedge HCLK);
        apb_read(a(VALUE_OFF), d, err);
        check("per_value_reload", d, 32'd3);
        check_rise("per_first_irq", 0, e0, 4);
        check_rise("per_second_irq", 1, e0, 8);

        // Clear coinciding with underflow (LOAD=0 underflows every tick)
        apb_write(a(LOAD_OFF), 32'd0, c, err);
        apb_write(a(INTSTAT_OFF), 32'h1, c, err);
        check("clr_on_uf_tint", {31'h0, TIMERINT}, 32'h1);
        apb_read(a(INTSTAT_OFF), d, err);
        check("clr_on_uf_stat", d, 32'h1);

        apb_write(a(CTRL_OFF), 32'h0, c, err);
        apb_write(a(INTSTAT_OFF), 32'h1, c, err);
        apb_read(a(INTSTAT_OFF), d, err);
        check("clr_idle_stat", d, 32'h0);

        // One-shot with PRESCALE=3, LOAD=2
        apb_write(a(LOAD_OFF), 32'd2, c, err);
        rise_q.delete();
        apb_write(a(CTRL_OFF), 32'h0303, e0, err);
        repeat (14) @(posedge HCLK);
        check_rise("os_irq_time", 0, e0, 12);
        apb_read(a(CTRL_OFF), d, err);  check("os_ctrl", d, 32'h0302);
        apb_read(a(VALUE_OFF), d, err); check("os_value", d, 32'h0);

        // Unmapped access
        apb_write(16'h0010, 32'hDEAD, c, err);
        check("err_wr_pslverr", {31'h0, err}, 32'h1);
        apb_read(16'h0010, d, err);
        check("err_rd_data", d, 32'h0);
        check("err_rd_pslverr", {31'h0, err}, 32'h1);
        apb_read(a(CTRL_OFF), d, err);    check("err_ctrl_kept", d, 32'h0302);
        apb_read(a(LOAD_OFF), d, err);    check("err_load_kept", d, 32'd2);
        apb_read(a(INTSTAT_OFF), d, err); check("err_stat_kept", d, 32'h1);

        // VALUE is read-only, no error
        apb_write(a(VALUE_OFF), 32'h55, c, err);
        check("ro_wr_pslverr", {31'h0, err}, 32'h0);
        apb_read(a(VALUE_OFF), d, err);
        check("ro_value", d, 32'h0);

        // LOAD write while counting
        apb_write(a(LOAD_OFF), 32'd50, c, err);
        apb_write(a(CTRL_OFF), 32'h3, c, err);
        repeat (3) @(posedge HCLK);
        apb_write(a(LOAD_OFF), 32'd100, c, err);
        apb_read(a(VALUE_OFF), d, err);
        check("midload_value", d, 32'd98);

        // Asynchronous reset in the middle of a cycle
        @(posedge HCLK); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = a(LOAD_OFF);
        #2;
        check("pre_rst_prdata", bus.PRDATA, 32'd100);
        check("pre_rst_tint", {31'h0, TIMERINT}, 32'h1);
        HRESETn = 1'b0;
        #1;
        check("async_rst_prdata", bus.PRDATA, 32'h0);
        check("async_rst_tint", {31'h0, TIMERINT}, 32'h0);
        check("async_rst_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
        check("async_rst_pready", {31'h0, bus.PREADY}, 32'h1);
        bus.PSEL = 0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        apb_read(a(CTRL_OFF), d, err);    check("post_rst_ctrl", d, 32'h0);
        apb_read(a(LOAD_OFF), d, err);    check("post_rst_load", d, 32'h0);
        apb_read(a(VALUE_OFF), d, err);   check("post_rst_value", d, 32'h0);
        apb_read(a(INTSTAT_OFF), d, err); check("post_rst_intstat", d, 32'h0);

        repeat (2) @(posedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
